// File: rtl/hazard_pkg.sv
// hazard_pkg: shared latency/select constants and the shadow-pipeline slot type for hazard_fwd_unit_id
package hazard_pkg;
  localparam int LAT_ALU = 1;
  localparam int LAT_LOAD = 2;
  localparam int SEL_RF = 0;
  localparam int NB_ADDR_MAX = 8;
  localparam int NB_LAT_MAX = 4;
  typedef struct packed {
    logic valid;
    logic [NB_ADDR_MAX-1:0] rd;
    logic [NB_LAT_MAX-1:0] lat;
  } slot_t;
  function automatic logic lat_legal(input int lat, input int n_stages);
    return lat >= LAT_ALU && lat < n_stages;
  endfunction
endpackage

// File: rtl/hazard_fwd_unit_id_if.sv
// hazard_fwd_unit_id_if: ID operand/producer info toward the hazard unit, forwarding selects and stall back
interface hazard_fwd_unit_id_if #(
  parameter int NB_ADDR = 5,
  parameter int NB_LAT = 2,
  parameter int NB_SEL = 2
);
  logic i_hold;
  logic i_valid_id;
  logic i_flush_id;
  logic [NB_ADDR-1:0] i_rs_id;
  logic [NB_ADDR-1:0] i_rt_id;
  logic i_use_rs_id;
  logic i_use_rt_id;
  logic [NB_ADDR-1:0] i_rd_id;
  logic i_regWrite_id;
  logic [NB_LAT-1:0] i_lat_id;
  logic [NB_SEL-1:0] o_forwardA_sel;
  logic [NB_SEL-1:0] o_forwardB_sel;
  logic o_stall;
  modport master (
    output i_hold, i_valid_id, i_flush_id, i_rs_id, i_rt_id, i_use_rs_id, i_use_rt_id,
           i_rd_id, i_regWrite_id, i_lat_id,
    input  o_forwardA_sel, o_forwardB_sel, o_stall
  );
  modport slave (
    input  i_hold, i_valid_id, i_flush_id, i_rs_id, i_rt_id, i_use_rs_id, i_use_rt_id,
           i_rd_id, i_regWrite_id, i_lat_id,
    output o_forwardA_sel, o_forwardB_sel, o_stall
  );
endinterface

// File: rtl/fwd_match_sel.sv
// fwd_match_sel: youngest-producer priority match for one ID operand, giving a forward select or a stall request
module fwd_match_sel
  import hazard_pkg::*;
#(
  parameter int N_STAGES = 3,
  parameter int NB_SEL = $clog2(N_STAGES)
) (
  input  slot_t [N_STAGES-1:0]  slots,
  input  logic [NB_ADDR_MAX-1:0] src,
  input  logic                  use_src,
  output logic [NB_SEL-1:0]     sel,
  output logic                  stall_req
);
  // scan oldest to youngest so the lowest matching slot overwrites older hits
  always_comb begin
    sel = NB_SEL'(SEL_RF);
    stall_req = 1'b0;
    for (int k = N_STAGES - 1; k >= 0; k--)
      if (use_src && src != '0 && slots[k].valid && slots[k].rd == src) begin
        stall_req = k < int'(slots[k].lat);
        sel = stall_req ? NB_SEL'(SEL_RF) : NB_SEL'(k);
      end
  end
endmodule

// File: rtl/hazard_fwd_unit_id.sv
// hazard_fwd_unit_id: ID-stage forwarding/stall unit over a shadow pipeline of destinations.
// Defining HAZ_STATS_EN adds saturating stall/forward cycle counters for the debug unit.
module hazard_fwd_unit_id
  import hazard_pkg::*;
#(
  parameter int NB_ADDR = 5,
  parameter int N_STAGES = 3,
  parameter int NB_LAT = 2,
  parameter int NB_SEL = $clog2(N_STAGES)
) (
  input logic i_clk,
  input logic i_rst,
  hazard_fwd_unit_id_if.slave bus
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_fwd_cnt
`endif
);
  slot_t [N_STAGES-1:0] slots;
  slot_t head;
  logic req_a, req_b, bubble;
  fwd_match_sel #(.N_STAGES(N_STAGES), .NB_SEL(NB_SEL)) u_match_a (
    .slots(slots),
    .src(NB_ADDR_MAX'(bus.i_rs_id)),
    .use_src(bus.i_use_rs_id),
    .sel(bus.o_forwardA_sel),
    .stall_req(req_a)
  );
  fwd_match_sel #(.N_STAGES(N_STAGES), .NB_SEL(NB_SEL)) u_match_b (
    .slots(slots),
    .src(NB_ADDR_MAX'(bus.i_rt_id)),
    .use_src(bus.i_use_rt_id),
    .sel(bus.o_forwardB_sel),
    .stall_req(req_b)
  );
  assign bus.o_stall = bus.i_valid_id & ~bus.i_flush_id & (req_a | req_b);
  assign bubble = bus.o_stall | bus.i_flush_id | ~bus.i_valid_id;
  assign head = bubble ? '0 : slot_t'{
    valid: bus.i_regWrite_id & (bus.i_rd_id != '0),
    rd:    NB_ADDR_MAX'(bus.i_rd_id),
    lat:   NB_LAT_MAX'(bus.i_lat_id)
  };
  always_ff @(posedge i_clk)
    if (i_rst) slots <= '0;
    else if (!bus.i_hold) slots <= {slots[N_STAGES-2:0], head};
`ifdef HAZ_STATS_EN
  always_ff @(posedge i_clk)
    if (i_rst) begin
      o_stall_cnt <= '0;
      o_fwd_cnt <= '0;
    end else if (!bus.i_hold) begin
      if (bus.o_stall && !(&o_stall_cnt)) o_stall_cnt <= o_stall_cnt + 32'd1;
      if (!bus.o_stall && (|bus.o_forwardA_sel || |bus.o_forwardB_sel) && !(&o_fwd_cnt))
        o_fwd_cnt <= o_fwd_cnt + 32'd1;
    end
`endif
  // a producer whose latency reaches past the last slot would never become forwardable
  a_lat_legal: assert property (@(posedge i_clk) disable iff (i_rst)
    !(bus.i_valid_id && bus.i_regWrite_id && bus.i_rd_id != '0) ||
    lat_legal(int'(bus.i_lat_id), N_STAGES));
endmodule

// File: tb/tb_hazard_fwd_unit_id.sv
// tb_hazard_fwd_unit_id: directed and randomized checks against an issue-history reference model
module tb_hazard_fwd_unit_id;
  import hazard_pkg::*;
  localparam int NB_ADDR = 5;
  localparam int N_STAGES = 3;
  localparam int NB_LAT = 2;
  localparam int NB_SEL = 2;
  typedef struct {bit v; int rd; int lat;} instr_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  instr_t hist[$];
  int m_stall, m_fwd;
  slot_t [N_STAGES-1:0] snap;
  always #5 clk = ~clk;
  hazard_fwd_unit_id_if #(.NB_ADDR(NB_ADDR), .NB_LAT(NB_LAT), .NB_SEL(NB_SEL)) bus();
`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt, fwd_cnt;
  int base;
`endif
  hazard_fwd_unit_id #(.NB_ADDR(NB_ADDR), .N_STAGES(N_STAGES), .NB_LAT(NB_LAT), .NB_SEL(NB_SEL)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
`ifdef HAZ_STATS_EN
    ,
    .o_stall_cnt(stall_cnt),
    .o_fwd_cnt(fwd_cnt)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // hist[d] is the instruction issued d cycles ago (d = 0 sits in EX)
  function automatic void model_op(input int src, input bit use_src, output int sel, output bit req);
    sel = SEL_RF;
    req = 1'b0;
    if (use_src && src != 0)
      for (int d = 0; d < N_STAGES; d++)
        if (hist[d].v && hist[d].rd == src) begin
          req = d < hist[d].lat;
          sel = req ? SEL_RF : d;
          break;
        end
  endfunction
  function automatic void model_reset();
    hist.delete();
    repeat (N_STAGES) hist.push_back('{0, 0, 0});
    m_stall = 0;
    m_fwd = 0;
  endfunction
  task automatic drive(input bit v, input bit fl, input int rs, input bit urs, input int rt, input bit urt,
                       input int rd, input bit rw, input int lat, input bit hold);
    bus.i_valid_id = v;
    bus.i_flush_id = fl;
    bus.i_rs_id = rs[NB_ADDR-1:0];
    bus.i_use_rs_id = urs;
    bus.i_rt_id = rt[NB_ADDR-1:0];
    bus.i_use_rt_id = urt;
    bus.i_rd_id = rd[NB_ADDR-1:0];
    bus.i_regWrite_id = rw;
    bus.i_lat_id = lat[NB_LAT-1:0];
    bus.i_hold = hold;
  endtask
  task automatic issue(input int rd, input int lat);
    drive(1, 0, 0, 0, 0, 0, rd, 1, lat, 0);
  endtask
  task automatic br(input int rs, input bit urs, input int rt, input bit urt, input bit hold = 0, input bit fl = 0);
    drive(1, fl, rs, urs, rt, urt, 0, 0, LAT_ALU, hold);
  endtask
  task automatic step(input string tag, input int x_stall = -1, input int x_sa = -1, input int x_sb = -1);
    int sa, sb;
    bit ra, rb, st;
    instr_t e;
    #1;
    model_op(int'(bus.i_rs_id), bus.i_use_rs_id, sa, ra);
    model_op(int'(bus.i_rt_id), bus.i_use_rt_id, sb, rb);
    st = bus.i_valid_id && !bus.i_flush_id && (ra || rb);
    check({tag, ".sel_a"}, 32'(bus.o_forwardA_sel), 32'(sa));
    check({tag, ".sel_b"}, 32'(bus.o_forwardB_sel), 32'(sb));
    check({tag, ".stall"}, 32'(bus.o_stall), 32'(st));
    if (x_stall >= 0) check({tag, ".stall_k"}, 32'(bus.o_stall), 32'(x_stall));
    if (x_sa >= 0) check({tag, ".sel_a_k"}, 32'(bus.o_forwardA_sel), 32'(x_sa));
    if (x_sb >= 0) check({tag, ".sel_b_k"}, 32'(bus.o_forwardB_sel), 32'(x_sb));
    e = '{0, 0, 0};
    if (!(st || bus.i_flush_id || !bus.i_valid_id))
      e = '{bus.i_regWrite_id && bus.i_rd_id != 0, int'(bus.i_rd_id), int'(bus.i_lat_id)};
    @(posedge clk);
    if (rst) model_reset();
    else if (!bus.i_hold) begin
      if (st) m_stall++;
      else if (sa != 0 || sb != 0) m_fwd++;
      hist.push_front(e);
      void'(hist.pop_back());
    end
    #1;
  endtask
  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, LAT_ALU, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    br(3, 1, 0, 0);
    check("rst.slots", {29'd0, dut.slots[2].valid, dut.slots[1].valid, dut.slots[0].valid}, 32'd0);
    step("rst", 0, 0, 0);
    issue(5, LAT_ALU);
    step("alu.prod");
    br(5, 1, 0, 0);
    step("alu.b0", 1, 0, 0);
    step("alu.b1", 0, 1, 0);
    step("alu.b2", 0, 2, 0);
    issue(7, LAT_LOAD);
    step("ld.prod");
    br(0, 0, 7, 1);
    step("ld.s0", 1, 0, 0);
    step("ld.s1", 1, 0, 0);
    check("ld.bubbles", {30'd0, dut.slots[1].valid, dut.slots[0].valid}, 32'd0);
    step("ld.fwd", 0, 0, 2);
    issue(4, LAT_ALU);
    step("yw.old");
    issue(4, LAT_ALU);
    step("yw.new");
    br(4, 1, 4, 1);
    step("yw.s", 1, 0, 0);
    step("yw.fwd", 0, 1, 1);
    issue(0, LAT_ALU);
    step("z.prod");
    br(0, 1, 0, 1);
    step("z.br", 0, 0, 0);
    issue(7, LAT_LOAD);
    step("fl.prod");
    br(0, 0, 7, 1, 0, 1);
    step("fl", 0, 0, 0);
    check("fl.slot0", 32'(dut.slots[0].valid), 32'd0);
    check("fl.slot1", 32'(dut.slots[1].rd), 32'd7);
    issue(9, LAT_LOAD);
    step("h.prod");
`ifdef HAZ_STATS_EN
    base = int'(stall_cnt);
`endif
    br(9, 1, 0, 0);
    step("h.s0", 1, 0, 0);
    br(9, 1, 0, 0, 1);
    snap = dut.slots;
    repeat (3) step("h.hold", 1, 0, 0);
    check("h.slots", 32'(dut.slots == snap), 32'd1);
    br(9, 1, 0, 0);
    step("h.s1", 1, 0, 0);
    step("h.fwd", 0, 2, 0);
`ifdef HAZ_STATS_EN
    check("h.stall_cnt", stall_cnt - 32'(base), 32'd2);
`endif
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 99) < 2;
      drive($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10,
            int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
            int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(LAT_ALU, LAT_LOAD)),
            $urandom_range(0, 99) < 10);
      step("rnd");
      rst = 1'b0;
    end
`ifdef HAZ_STATS_EN
    check("stall_cnt", stall_cnt, 32'(m_stall));
    check("fwd_cnt", fwd_cnt, 32'(m_fwd));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
